// File: rtl/matrix_mult_if.sv
// Operand/result bundle between the serial data loader and the matrix multiplier.
// The loader drives both packed operands, dimensions and the start level; the multiplier returns the result.
interface matrix_mult_if;
    logic [63:0] matrix_1;
    logic [63:0] matrix_2;
    logic [3:0]  R1;
    logic [3:0]  C1;
    logic [3:0]  R2;
    logic [3:0]  C2;
    logic        readybit;
    logic [63:0] res_mat;

    modport master (
        output matrix_1, matrix_2, R1, C1, R2, C2, readybit,
        input  res_mat
    );

    modport slave (
        input  matrix_1, matrix_2, R1, C1, R2, C2, readybit,
        output res_mat
    );
endinterface

// File: rtl/matrix_mult.sv
// Sequential unsigned multiplier for up to 2x2 matrices of 16-bit elements, one output element per cycle.
// Result registered R1*C2 cycles after the readybit rising edge is latched; no backpressure, readybit is a level start request.
module matrix_mult #(
    parameter int MAX_DIM = 2,
    parameter int EW      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    matrix_mult_if.slave  mm
);
    localparam int SLOTS = MAX_DIM * MAX_DIM;
    localparam int WW    = SLOTS * EW;
    localparam logic [3:0] MAXD = 4'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic            rdy_prev;
    logic            rise;
    logic            dims_ok;

    logic [WW-1:0]   a_q;
    logic [WW-1:0]   b_q;
    // Only valid dims (1..2) ever reach CALC, so two bits per dim suffice; R2 equals C1 there.
    logic [1:0]      r1_q;
    logic [1:0]      c1_q;
    logic [1:0]      c2_q;
    logic [1:0]      idx_q;
    logic [EW-1:0]   elem_buf [SLOTS];
    logic [WW-1:0]   res_q;

    logic [EW-1:0]   a_el [SLOTS];
    logic [EW-1:0]   b_el [SLOTS];
    logic [1:0]      row;
    logic [1:0]      col;
    logic [1:0]      kk;
    logic [1:0]      a_idx;
    logic [1:0]      b_idx;
    logic [EW-1:0]   prod;
    logic [EW-1:0]   dot;
    logic            last;
    logic [WW-1:0]   res_next;

    assign rise = mm.readybit & ~rdy_prev;

    assign dims_ok = (mm.R1 != 4'd0) && (mm.R1 <= MAXD) &&
                     (mm.C1 != 4'd0) && (mm.C1 <= MAXD) &&
                     (mm.R2 != 4'd0) && (mm.R2 <= MAXD) &&
                     (mm.C2 != 4'd0) && (mm.C2 <= MAXD) &&
                     (mm.C1 == mm.R2);

    assign last = (idx_q == r1_q * c2_q - 2'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = dims_ok ? CALC : DONE;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!mm.readybit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            a_el[s] = a_q[WW-1-EW*s -: EW];
            b_el[s] = b_q[WW-1-EW*s -: EW];
        end
    end

    // Row-major element index -> (row, col) without a divider: C2 is 1 or 2.
    always_comb begin
        if (c2_q == 2'd1) begin
            row = idx_q;
            col = 2'd0;
        end else begin
            row = {1'b0, idx_q[1]};
            col = {1'b0, idx_q[0]};
        end
    end

    // Full dot product for the current element; truncation to EW bits gives the mod-2^16 wrap.
    always_comb begin
        dot   = '0;
        kk    = 2'd0;
        a_idx = 2'd0;
        b_idx = 2'd0;
        prod  = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            kk    = 2'(k);
            a_idx = row * c1_q + kk;
            b_idx = kk * c2_q + col;
            prod  = a_el[a_idx] * b_el[b_idx];
            if (kk < c1_q) begin
                dot = dot + prod;
            end
        end
    end

    // Buffer snapshot with the element being finished this cycle folded in; untouched slots stay 0.
    always_comb begin
        res_next = '0;
        for (int s = 0; s < SLOTS; s++) begin
            res_next[WW-1-EW*s -: EW] = (2'(s) == idx_q) ? dot : elem_buf[s];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdy_prev <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            r1_q     <= 2'd0;
            c1_q     <= 2'd0;
            c2_q     <= 2'd0;
            idx_q    <= 2'd0;
            res_q    <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                elem_buf[s] <= '0;
            end
        end else begin
            rdy_prev <= mm.readybit;
            case (state)
                IDLE: begin
                    if (rise) begin
                        a_q   <= mm.matrix_1;
                        b_q   <= mm.matrix_2;
                        r1_q  <= mm.R1[1:0];
                        c1_q  <= mm.C1[1:0];
                        c2_q  <= mm.C2[1:0];
                        idx_q <= 2'd0;
                        for (int s = 0; s < SLOTS; s++) begin
                            elem_buf[s] <= '0;
                        end
                        if (!dims_ok) begin
                            res_q <= '0;
                        end
                    end
                end
                CALC: begin
                    elem_buf[idx_q] <= dot;
                    idx_q           <= idx_q + 2'd1;
                    if (last) begin
                        res_q <= res_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mm.res_mat = res_q;
endmodule

// File: tb/tb_matrix_mult.sv
// Directed self-checking bench for matrix_mult: timing, wrap, invalid dims, reset abort and operand latching.
module tb_matrix_mult;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    localparam logic [63:0] A1   = 64'h0001_0002_0003_0004;
    localparam logic [63:0] B1   = 64'h0005_0006_0007_0008;
    localparam logic [63:0] A2   = 64'h0002_0000_0000_0002;
    localparam logic [63:0] R_AB = 64'h0013_0016_002B_0032;
    localparam logic [63:0] R_2B = 64'h000A_000C_000E_0010;

    matrix_mult_if bus ();

    matrix_mult dut (
        .CLK (CLK),
        .RST (RST),
        .mm  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] r1, input logic [3:0] c1,
                        input logic [3:0] r2, input logic [3:0] c2);
        bus.matrix_1 = a;
        bus.matrix_2 = b;
        bus.R1 = r1;
        bus.C1 = c1;
        bus.R2 = r2;
        bus.C2 = c2;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        bus.readybit = 1'b0;
        load(64'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        tick(2);
        checks++;
        if (bus.res_mat !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: res_mat=%h expected %h", bus.res_mat, 64'h0);
        end
        RST = 1'b0;
        tick(1);
    endtask

    task automatic test_2x2;
        load(A1, B1, 4'd2, 4'd2, 4'd2, 4'd2);
        bus.readybit = 1'b1;
        tick(1);
        tick(3);
        checks++;
        if (bus.res_mat !== 64'h0) begin
            errors++;
            $display("FAIL 2x2_partial: res_mat=%h expected %h", bus.res_mat, 64'h0);
        end
        tick(1);
        checks++;
        if (bus.res_mat !== R_AB) begin
            errors++;
            $display("FAIL 2x2_result: res_mat=%h expected %h", bus.res_mat, R_AB);
        end
        // New operands while readybit stays high must not start another job.
        bus.matrix_1 = A2;
        tick(6);
        checks++;
        if (bus.res_mat !== R_AB) begin
            errors++;
            $display("FAIL 2x2_hold: res_mat=%h expected %h", bus.res_mat, R_AB);
        end
        bus.readybit = 1'b0;
        tick(2);
    endtask

    task automatic test_1x2_2x1;
        load(64'h0003_0004_DEAD_BEEF, 64'h0005_0006_1234_5678, 4'd1, 4'd2, 4'd2, 4'd1);
        bus.readybit = 1'b1;
        tick(1);
        tick(2);
        checks++;
        if (bus.res_mat !== 64'h0027_0000_0000_0000) begin
            errors++;
            $display("FAIL 1x2_by_2x1: res_mat=%h expected %h", bus.res_mat, 64'h0027_0000_0000_0000);
        end
        bus.readybit = 1'b0;
        tick(2);
    endtask

    task automatic test_overflow;
        load(64'h0101_FFFF_FFFF_FFFF, 64'h0101_AAAA_AAAA_AAAA, 4'd1, 4'd1, 4'd1, 4'd1);
        bus.readybit = 1'b1;
        tick(1);
        checks++;
        if (bus.res_mat !== 64'h0027_0000_0000_0000) begin
            errors++;
            $display("FAIL ovf_at_latch: res_mat=%h expected %h", bus.res_mat, 64'h0027_0000_0000_0000);
        end
        tick(1);
        checks++;
        if (bus.res_mat !== 64'h0201_0000_0000_0000) begin
            errors++;
            $display("FAIL ovf_wrap: res_mat=%h expected %h", bus.res_mat, 64'h0201_0000_0000_0000);
        end
        bus.readybit = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid;
        load(A1, B1, 4'd2, 4'd2, 4'd2, 4'd2);
        bus.readybit = 1'b1;
        tick(1);
        tick(2);
        RST = 1'b1;
        bus.readybit = 1'b0;
        tick(1);
        checks++;
        if (bus.res_mat !== 64'h0) begin
            errors++;
            $display("FAIL rst_clear: res_mat=%h expected %h", bus.res_mat, 64'h0);
        end
        RST = 1'b0;
        tick(5);
        checks++;
        if (bus.res_mat !== 64'h0) begin
            errors++;
            $display("FAIL rst_abort: res_mat=%h expected %h", bus.res_mat, 64'h0);
        end
        bus.readybit = 1'b1;
        tick(1);
        tick(4);
        checks++;
        if (bus.res_mat !== R_AB) begin
            errors++;
            $display("FAIL rst_restart: res_mat=%h expected %h", bus.res_mat, R_AB);
        end
        bus.readybit = 1'b0;
        tick(2);
    endtask

    task automatic test_invalid;
        for (int pass = 0; pass < 2; pass++) begin
            load(64'h0003_0000_0000_0000, 64'h0003_0000_0000_0000, 4'd1, 4'd1, 4'd1, 4'd1);
            bus.readybit = 1'b1;
            tick(2);
            checks++;
            if (bus.res_mat !== 64'h0009_0000_0000_0000) begin
                errors++;
                $display("FAIL inv_pre%0d: res_mat=%h expected %h", pass, bus.res_mat, 64'h0009_0000_0000_0000);
            end
            bus.readybit = 1'b0;
            tick(2);
            if (pass == 0) load(A1, B1, 4'd2, 4'd2, 4'd1, 4'd2);
            else           load(A1, B1, 4'd1, 4'd0, 4'd0, 4'd1);
            bus.readybit = 1'b1;
            tick(1);
            tick(1);
            checks++;
            if (bus.res_mat !== 64'h0) begin
                errors++;
                $display("FAIL inv_dims%0d: res_mat=%h expected %h", pass, bus.res_mat, 64'h0);
            end
            bus.readybit = 1'b0;
            tick(2);
        end
    endtask

    task automatic test_latch_hold;
        load(A1, B1, 4'd2, 4'd2, 4'd2, 4'd2);
        bus.readybit = 1'b1;
        tick(1);
        bus.matrix_1 = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.R1 = 4'd1;
        tick(1);
        bus.readybit = 1'b0;
        tick(2);
        checks++;
        if (bus.res_mat !== 64'h0) begin
            errors++;
            $display("FAIL hold_partial: res_mat=%h expected %h", bus.res_mat, 64'h0);
        end
        tick(1);
        checks++;
        if (bus.res_mat !== R_AB) begin
            errors++;
            $display("FAIL hold_latched: res_mat=%h expected %h", bus.res_mat, R_AB);
        end
        tick(2);
        load(A2, B1, 4'd2, 4'd2, 4'd2, 4'd2);
        bus.readybit = 1'b1;
        tick(1);
        tick(4);
        checks++;
        if (bus.res_mat !== R_2B) begin
            errors++;
            $display("FAIL back_to_back: res_mat=%h expected %h", bus.res_mat, R_2B);
        end
        bus.readybit = 1'b0;
        tick(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        bus.readybit = 1'b0;
        load(64'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_2x2();
        test_1x2_2x1();
        test_overflow();
        test_reset_mid();
        test_invalid();
        test_latch_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
